// File: rtl/mem_port_arbiter.sv
// Two-requester (CPU, loader) arbiter for a single memory port with locked loader
// bursts, in-order read-return routing and a contention counter.
module mem_port_arbiter #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic              CLK,
  input  logic              CtrlRst,
  input  logic              CpuReq,
  input  logic              CpuWe,
  input  logic [ADDR_W-1:0] CpuAddr,
  input  logic [DATA_W-1:0] CpuWData,
  output logic              CpuGnt,
  output logic              CpuStall,
  output logic [DATA_W-1:0] CpuRData,
  output logic              CpuValid,
  input  logic              LdrReq,
  input  logic              LdrWe,
  input  logic              LdrLock,
  input  logic [ADDR_W-1:0] LdrAddr,
  input  logic [DATA_W-1:0] LdrWData,
  output logic              LdrGnt,
  output logic [DATA_W-1:0] LdrRData,
  output logic              LdrValid,
  output logic              MemEn,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  input  logic [DATA_W-1:0] MemRData,
  output logic [15:0]       ContendCnt
);

  localparam logic [3:0] BurstMax = 4'(MAX_BURST);

  logic              cpu_gnt_s;
  logic              ldr_gnt_s;
  logic              rd_acc_s;
  logic              last_ldr_q, last_ldr_d;
  logic [3:0]        burst_q, burst_d;
  logic              pend_vld_q;
  logic              pend_ldr_q;
  logic              cpu_valid_q, ldr_valid_q;
  logic [DATA_W-1:0] cpu_rdata_q, ldr_rdata_q;
  logic [15:0]       contend_q, contend_d;

  // Grant selection; an active locked burst outranks plain alternation.
  always_comb begin
    cpu_gnt_s = 1'b0;
    ldr_gnt_s = 1'b0;
    if (!CtrlRst) begin
      cpu_gnt_s = 1'b0;
      ldr_gnt_s = 1'b0;
    end else if (CpuReq && LdrReq) begin
      if (LdrLock && (burst_q != 4'd0) && (burst_q < BurstMax)) begin
        ldr_gnt_s = 1'b1;
      end else if (burst_q >= BurstMax) begin
        cpu_gnt_s = 1'b1;
      end else if (last_ldr_q) begin
        cpu_gnt_s = 1'b1;
      end else begin
        ldr_gnt_s = 1'b1;
      end
    end else if (CpuReq) begin
      cpu_gnt_s = 1'b1;
    end else if (LdrReq) begin
      ldr_gnt_s = 1'b1;
    end else begin
      cpu_gnt_s = 1'b0;
      ldr_gnt_s = 1'b0;
    end
  end

  // Shared memory port mux, all zero when idle.
  always_comb begin
    MemEn    = cpu_gnt_s | ldr_gnt_s;
    MemWe    = 1'b0;
    MemAddr  = '0;
    MemWData = '0;
    if (cpu_gnt_s) begin
      MemWe    = CpuWe;
      MemAddr  = CpuAddr;
      MemWData = CpuWData;
    end else if (ldr_gnt_s) begin
      MemWe    = LdrWe;
      MemAddr  = LdrAddr;
      MemWData = LdrWData;
    end else begin
      MemWe    = 1'b0;
      MemAddr  = '0;
      MemWData = '0;
    end
  end

  assign rd_acc_s = (cpu_gnt_s & ~CpuWe) | (ldr_gnt_s & ~LdrWe);

  // Next state for last-grant, burst length and contention count.
  always_comb begin
    last_ldr_d = last_ldr_q;
    burst_d    = burst_q;
    contend_d  = contend_q;
    if (cpu_gnt_s) begin
      last_ldr_d = 1'b0;
      burst_d    = 4'd0;
    end else if (ldr_gnt_s) begin
      last_ldr_d = 1'b1;
      if (!LdrLock) begin
        burst_d = 4'd0;
      end else if (burst_q < BurstMax) begin
        burst_d = burst_q + 4'd1;
      end else begin
        burst_d = burst_q;
      end
    end else if (!LdrReq) begin
      burst_d = 4'd0;
    end else begin
      burst_d = burst_q;
    end
    if (CpuReq && LdrReq && (contend_q != 16'hFFFF)) begin
      contend_d = contend_q + 16'd1;
    end else begin
      contend_d = contend_q;
    end
  end

  // State registers; the tag pipeline steers returning read data to its owner.
  always_ff @(posedge CLK or negedge CtrlRst) begin
    if (!CtrlRst) begin
      last_ldr_q  <= 1'b1;
      burst_q     <= 4'd0;
      contend_q   <= 16'd0;
      pend_vld_q  <= 1'b0;
      pend_ldr_q  <= 1'b0;
      cpu_valid_q <= 1'b0;
      ldr_valid_q <= 1'b0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      last_ldr_q  <= last_ldr_d;
      burst_q     <= burst_d;
      contend_q   <= contend_d;
      pend_vld_q  <= rd_acc_s;
      pend_ldr_q  <= ldr_gnt_s;
      cpu_valid_q <= pend_vld_q & ~pend_ldr_q;
      ldr_valid_q <= pend_vld_q & pend_ldr_q;
      if (pend_vld_q && !pend_ldr_q) begin
        cpu_rdata_q <= MemRData;
      end
      if (pend_vld_q && pend_ldr_q) begin
        ldr_rdata_q <= MemRData;
      end
    end
  end

  assign CpuGnt     = cpu_gnt_s;
  assign LdrGnt     = ldr_gnt_s;
  assign CpuStall   = CpuReq & ~cpu_gnt_s;
  assign CpuValid   = cpu_valid_q;
  assign LdrValid   = ldr_valid_q;
  assign CpuRData   = cpu_rdata_q;
  assign LdrRData   = ldr_rdata_q;
  assign ContendCnt = contend_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised and directed bench for mem_port_arbiter: a rule-level arbitration model
// predicts grants, and a read-return scoreboard is drained by an independent monitor.
module tb_mem_port_arbiter;
  localparam int MAXB = 4;

  logic        CLK = 1'b0;
  logic        CtrlRst = 1'b0;
  logic        CpuReq = 1'b0, CpuWe = 1'b0;
  logic [15:0] CpuAddr = 16'd0, CpuWData = 16'd0;
  logic        CpuGnt, CpuStall, CpuValid;
  logic [15:0] CpuRData;
  logic        LdrReq = 1'b0, LdrWe = 1'b0, LdrLock = 1'b0;
  logic [15:0] LdrAddr = 16'd0, LdrWData = 16'd0;
  logic        LdrGnt, LdrValid;
  logic [15:0] LdrRData;
  logic        MemEn, MemWe;
  logic [15:0] MemAddr, MemWData, MemRData, ContendCnt;

  mem_port_arbiter #(.DATA_W(16), .ADDR_W(16), .MAX_BURST(MAXB)) dut (
    .CLK(CLK), .CtrlRst(CtrlRst),
    .CpuReq(CpuReq), .CpuWe(CpuWe), .CpuAddr(CpuAddr), .CpuWData(CpuWData),
    .CpuGnt(CpuGnt), .CpuStall(CpuStall), .CpuRData(CpuRData), .CpuValid(CpuValid),
    .LdrReq(LdrReq), .LdrWe(LdrWe), .LdrLock(LdrLock), .LdrAddr(LdrAddr), .LdrWData(LdrWData),
    .LdrGnt(LdrGnt), .LdrRData(LdrRData), .LdrValid(LdrValid),
    .MemEn(MemEn), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData), .ContendCnt(ContendCnt)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  logic [15:0] mem [256];
  logic [15:0] ref_mem [256];
  logic [16:0] sb [$];
  int m_last_ldr = 1;
  int m_burst = 0;
  int m_contend = 0;
  int obs_w = 0;
  int exp_w = 0;
  int stall_cnt = 0;
  int seq [5];

  // Memory behind the shared port: read data appears after the sampling edge.
  always @(posedge CLK) begin
    if (MemEn && MemWe) mem[MemAddr[7:0]] = MemWData;
    if (MemEn && !MemWe) MemRData <= mem[MemAddr[7:0]];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: each Valid strobe must match the oldest outstanding read.
  always @(negedge CLK) begin
    if (CtrlRst) begin
      if (CpuValid && LdrValid) chk("both_valid", 32'd1, 32'd0);
      if (CpuValid) begin
        if (sb.size() == 0) chk("cpu_spurious_valid", 32'd1, 32'd0);
        else begin
          logic [16:0] e;
          e = sb.pop_front();
          chk("cpu_ret_owner", 32'(e[16]), 32'd0);
          chk("cpu_ret_data", 32'(CpuRData), 32'(e[15:0]));
        end
      end
      if (LdrValid) begin
        if (sb.size() == 0) chk("ldr_spurious_valid", 32'd1, 32'd0);
        else begin
          logic [16:0] e;
          e = sb.pop_front();
          chk("ldr_ret_owner", 32'(e[16]), 32'd1);
          chk("ldr_ret_data", 32'(LdrRData), 32'(e[15:0]));
        end
      end
    end
  end

  // Winner by the arbitration rules: 0 none, 1 CPU, 2 loader.
  function automatic int exp_winner();
    if (!CpuReq && !LdrReq) return 0;
    if (!LdrReq) return 1;
    if (!CpuReq) return 2;
    if (LdrLock && m_burst > 0 && m_burst < MAXB) return 2;
    if (m_burst >= MAXB) return 1;
    return (m_last_ldr != 0) ? 1 : 2;
  endfunction

  task automatic cycle();
    int w;
    logic [15:0] ea, ed;
    logic ewe;
    @(negedge CLK);
    w = exp_winner();
    exp_w = w;
    obs_w = CpuGnt ? 1 : (LdrGnt ? 2 : 0);
    if (CpuStall) stall_cnt++;
    ewe = (w == 1) ? CpuWe : (w == 2) ? LdrWe : 1'b0;
    ea  = (w == 1) ? CpuAddr : (w == 2) ? LdrAddr : 16'd0;
    ed  = (w == 1) ? CpuWData : (w == 2) ? LdrWData : 16'd0;
    chk("cpu_gnt", 32'(CpuGnt), 32'(w == 1));
    chk("ldr_gnt", 32'(LdrGnt), 32'(w == 2));
    chk("cpu_stall", 32'(CpuStall), 32'(CpuReq && w != 1));
    chk("mem_en", 32'(MemEn), 32'(w != 0));
    chk("mem_we", 32'(MemWe), 32'(ewe));
    chk("mem_addr", 32'(MemAddr), 32'(ea));
    chk("mem_wdata", 32'(MemWData), 32'(ed));
    chk("contend_cnt", 32'(ContendCnt), 32'(m_contend));
    if (w != 0) begin
      if (ewe) ref_mem[ea[7:0]] = ed;
      else sb.push_back({(w == 2), ref_mem[ea[7:0]]});
    end
    if (w == 1) begin
      m_last_ldr = 0;
      m_burst = 0;
    end else if (w == 2) begin
      m_last_ldr = 1;
      m_burst = LdrLock ? ((m_burst < MAXB) ? m_burst + 1 : m_burst) : 0;
    end else if (!LdrReq) m_burst = 0;
    if (CpuReq && LdrReq && m_contend < 65535) m_contend++;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [15:0] a, input logic [15:0] d);
    CpuReq = req; CpuWe = we; CpuAddr = a; CpuWData = d;
  endtask

  task automatic set_ldr(input logic req, input logic we, input logic lk, input logic [15:0] a,
                         input logic [15:0] d);
    LdrReq = req; LdrWe = we; LdrLock = lk; LdrAddr = a; LdrWData = d;
  endtask

  task automatic reset_model();
    m_last_ldr = 1; m_burst = 0; m_contend = 0;
    sb.delete();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'(i * 257) ^ 16'h5A5A;
      ref_mem[i] = 16'(i * 257) ^ 16'h5A5A;
    end
    mem[16] = 16'hBEEF; ref_mem[16] = 16'hBEEF;
    mem[1]  = 16'h1111; ref_mem[1]  = 16'h1111;
    mem[2]  = 16'h2222; ref_mem[2]  = 16'h2222;

    // Reset: grants held off even with both requesting.
    set_cpu(1'b1, 1'b0, 16'h0020, 16'h0);
    set_ldr(1'b1, 1'b0, 1'b0, 16'h0021, 16'h0);
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_cpu_gnt", 32'(CpuGnt), 32'd0);
    chk("rst_ldr_gnt", 32'(LdrGnt), 32'd0);
    chk("rst_mem_en", 32'(MemEn), 32'd0);
    chk("rst_contend", 32'(ContendCnt), 32'd0);
    chk("rst_valids", 32'({CpuValid, LdrValid}), 32'd0);
    CtrlRst = 1'b1;
    cycle();
    chk("first_contest_cpu", 32'(obs_w), 32'd1);

    // CPU-only read of 0x0010.
    set_ldr(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_cpu(1'b1, 1'b0, 16'h0010, 16'h0);
    cycle();
    chk("cpu_only_gnt", 32'(obs_w), 32'd1);
    set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    cycle();
    chk("beef_valid", 32'(CpuValid), 32'd1);
    chk("beef_data", 32'(CpuRData), 32'hBEEF);
    chk("beef_ldr_valid", 32'(LdrValid), 32'd0);
    cycle();
    chk("beef_valid_drop", 32'(CpuValid), 32'd0);

    // Alternation with lock low, starting after a loader grant.
    set_ldr(1'b1, 1'b1, 1'b0, 16'h0030, 16'h3333);
    cycle();
    set_cpu(1'b1, 1'b0, 16'h0040, 16'h0);
    set_ldr(1'b1, 1'b1, 1'b0, 16'h0041, 16'hAAAA);
    begin
      int base;
      base = m_contend;
      for (int i = 0; i < 4; i++) begin
        cycle();
        seq[i] = obs_w;
      end
      chk("alt_seq", 32'({seq[0][1:0], seq[1][1:0], seq[2][1:0], seq[3][1:0]}), 32'b01_10_01_10);
      chk("alt_contend", 32'(ContendCnt), 32'(base + 4));
    end

    // Locked burst: loader takes MAX_BURST accesses, then the CPU.
    set_ldr(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    cycle();
    set_ldr(1'b1, 1'b1, 1'b1, 16'h0050, 16'h1234);
    stall_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      seq[i] = obs_w;
    end
    chk("burst_seq", 32'({seq[0][1:0], seq[1][1:0], seq[2][1:0], seq[3][1:0], seq[4][1:0]}),
        32'b10_10_10_10_01);
    chk("burst_stall_cycles", 32'(stall_cnt), 32'd4);
    set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    set_ldr(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (3) cycle();

    // Back-to-back reads from mixed owners.
    set_cpu(1'b1, 1'b0, 16'h0001, 16'h0);
    set_ldr(1'b1, 1'b0, 1'b0, 16'h0002, 16'h0);
    cycle();
    chk("mix_first_ldr", 32'(obs_w), 32'd2);
    set_ldr(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    cycle();
    chk("mix_second_cpu", 32'(obs_w), 32'd1);
    set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    chk("mix_ldr_valid", 32'({LdrValid, CpuValid}), 32'b10);
    chk("mix_ldr_data", 32'(LdrRData), 32'h2222);
    cycle();
    chk("mix_cpu_valid", 32'({LdrValid, CpuValid}), 32'b01);
    chk("mix_cpu_data", 32'(CpuRData), 32'h1111);
    chk("mix_ldr_hold", 32'(LdrRData), 32'h2222);
    cycle();
    chk("mix_valids_clear", 32'({LdrValid, CpuValid}), 32'd0);

    // Random traffic; requests only change once accepted or idle.
    for (int n = 0; n < 400; n++) begin
      cycle();
      if (exp_w == 1 || !CpuReq)
        set_cpu($urandom_range(0, 99) < 70, $urandom_range(0, 2) == 0,
                16'($urandom_range(0, 31)), 16'($urandom));
      if (exp_w == 2 || !LdrReq)
        set_ldr($urandom_range(0, 99) < 70, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                16'($urandom_range(0, 31)), 16'($urandom));
    end
    set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    set_ldr(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (4) cycle();
    chk("rand_drained", 32'(sb.size()), 32'd0);

    // Reset pulse with a read in flight drops the return.
    set_cpu(1'b1, 1'b0, 16'h0010, 16'h0);
    cycle();
    set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    CtrlRst = 1'b0;
    reset_model();
    #2;
    chk("pulse_rdata", 32'({CpuRData, LdrRData}), 32'd0);
    chk("pulse_contend", 32'(ContendCnt), 32'd0);
    chk("pulse_valids", 32'({CpuValid, LdrValid}), 32'd0);
    @(posedge CLK);
    #1;
    chk("pulse_valids_late", 32'({CpuValid, LdrValid}), 32'd0);
    CtrlRst = 1'b1;
    set_cpu(1'b1, 1'b0, 16'h0020, 16'h0);
    set_ldr(1'b1, 1'b0, 1'b1, 16'h0021, 16'h0);
    cycle();
    chk("post_rst_contest_cpu", 32'(obs_w), 32'd1);
    set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    set_ldr(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (4) cycle();
    chk("final_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: DATA_W, 16, memory data width.
REQ-002 Parameter: ADDR_W, 16, memory address width.
REQ-003 Parameter: MAX_BURST, 4, maximum consecutive locked loader grants (1..15).
REQ-004 CLK  in  1  single clock; all state updates on rising edge.
REQ-005 CtrlRst  in  1  reset, asynchronous, active-low.
REQ-006 CpuReq, CpuWe  in  1 each  CPU access request, write select.
REQ-007 CpuAddr  in  ADDR_W; CpuWData  in  DATA_W  CPU access address, write data.
REQ-008 CpuGnt  out  1  CPU access accepted this cycle; CpuStall  out  1  CPU waiting.
REQ-009 CpuRData  out  DATA_W; CpuValid  out  1  CPU read return data and strobe.
REQ-010 LdrReq, LdrWe, LdrLock  in  1 each  loader request, write select, burst lock.
REQ-011 LdrAddr  in  ADDR_W; LdrWData  in  DATA_W  loader address, write data.
REQ-012 LdrGnt  out  1; LdrRData  out  DATA_W; LdrValid  out  1  loader grant and read return.
REQ-013 MemEn, MemWe  out  1; MemAddr  out  ADDR_W; MemWData  out  DATA_W  shared memory port.
REQ-014 MemRData  in  DATA_W  valid the cycle after the edge that sampled a read command.
REQ-015 ContendCnt  out  16  count of cycles with both requests high.

Function
REQ-016 Grants combinational from Req inputs and registered state; at most one of CpuGnt/LdrGnt high per cycle.
REQ-017 Access accepted at the rising edge where Req && Gnt; one access per cycle, back-to-back accepted without bubbles.
REQ-018 Requester holds Req/We/Addr/WData stable until accepted.
REQ-019 Mem* combinationally mux the granted requester's fields; MemEn = CpuGnt | LdrGnt; all Mem* 0 when no grant.
REQ-020 Single requester: always granted.
REQ-021 Both requesting, no burst active: grant the requester not granted at the last accepted contested-or-uncontested access (LastGnt register).
REQ-022 Burst: loader accepted with LdrLock=1 starts/continues burst; loader keeps priority over CPU while LdrLock=1 and burst count < MAX_BURST.
REQ-023 Burst count increments per locked loader acceptance; reaching MAX_BURST forces next contested grant to CPU; count clears on any CPU acceptance, loader acceptance with LdrLock=0, or idle cycle with LdrReq=0.
REQ-024 CpuStall = CpuReq & ~CpuGnt.
REQ-025 Read return: 2-entry tag pipeline (valid, owner); read accepted at edge E0 -> RData register of owner loaded from MemRData at edge E1 -> owner Valid high exactly one cycle after E1.
REQ-026 xRData holds last returned value until the owner's next read return; writes never assert Valid.
REQ-027 Back-to-back reads from mixed owners each return in order, one per cycle, to the correct owner.
REQ-028 ContendCnt increments on each edge with CpuReq & LdrReq; saturates at 0xFFFF.

Reset
REQ-029 CtrlRst low: immediately CpuValid=LdrValid=0, CpuRData=LdrRData=0, ContendCnt=0, burst count=0, tag pipeline cleared, LastGnt=loader (CPU wins first contest).
REQ-030 Reads in flight at reset are dropped; no Valid after release.
REQ-031 Grants during reset: forced 0; first grant possible in the cycle after CtrlRst rises.

Verification
REQ-032 CPU-only read 0x0010, memory returns 0xBEEF -> CpuGnt same cycle, CpuValid one cycle after next edge, CpuRData=0xBEEF, LdrValid=0.
REQ-033 Both request continuously, LdrLock=0 -> grants alternate CPU,LDR,CPU,LDR; ContendCnt=4 after 4 edges.
REQ-034 Both request, LdrLock=1, MAX_BURST=4, loader currently granted -> loader wins 4 consecutive, then CPU granted; CpuStall high 4 cycles.
REQ-035 Alternating CPU read 0x0001 / loader read 0x0002 back-to-back, memory data 0x1111/0x2222 -> CpuRData=0x1111, LdrRData=0x2222, each Valid single-cycle, consecutive cycles.
REQ-036 Read accepted, CtrlRst pulsed low before return -> no Valid, RData=0, ContendCnt=0; first post-reset contest grants CPU.
